// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg : shared states, opcodes and key codes for the calculator sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [2:0] {
    S_OPA  = 3'd0,
    S_OPB  = 3'd1,
    S_RDY  = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_RES  = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_ASL  = 4'd11;
  localparam logic [3:0] OP_NONE = 4'hF;

  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Wide enough for mag*10+digit with mag up to 127 (max 1279).
  localparam int MAG_W = 11;

endpackage
`default_nettype wire

// File: rtl/calc_digit_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_digit_acc : decimal magnitude/sign accumulator producing a signed operand
// Revision : 1.0
// ---------------------------------------------------------------------------
module calc_digit_acc
  import calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_MAG = 127
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_value,
  input  logic              i_digit_valid,
  input  logic [3:0]        i_digit,
  input  logic              i_toggle,
  output logic              o_accept,
  output logic [DATA_W-1:0] o_operand
);

  logic [MAG_W-1:0]  r_mag;
  logic              r_sign;
  logic [MAG_W-1:0]  w_next_mag;
  logic [DATA_W-1:0] w_load_abs;
  logic [DATA_W-1:0] w_mag_trunc;

  always_comb begin
    w_next_mag  = r_mag * MAG_W'(10) + MAG_W'(i_digit);
    o_accept    = i_digit_valid && (w_next_mag <= MAG_W'(MAX_MAG));
    w_load_abs  = i_load_value[DATA_W-1] ? -i_load_value : i_load_value;
    w_mag_trunc = r_mag[DATA_W-1:0];
    o_operand   = r_sign ? -w_mag_trunc : w_mag_trunc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_mag  <= '0;
      r_sign <= 1'b0;
    end else if (i_load) begin
      // Loading a signed value splits it back into magnitude and sign.
      r_mag  <= MAG_W'(w_load_abs);
      r_sign <= i_load_value[DATA_W-1];
    end else begin
      if (o_accept) r_mag <= w_next_mag;
      if (i_toggle) r_sign <= ~r_sign;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_seq_ctrl : key-entry sequencer building operands and driving the ALU
// Revision : 1.0
// ---------------------------------------------------------------------------
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MAX_MAG     = 127,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  input  logic [3:0]        i_ctrl_hex_keycode,
  input  logic              i_ctrl_hex_valid,
  input  logic [3:0]        i_ctrl_op_keycode,
  input  logic              i_ctrl_op_valid,
  input  logic              i_ctrl_neg_flag,
  input  logic [DATA_W-1:0] i_ctrl_alu_result,
  input  logic              i_ctrl_alu_error,
  input  logic              i_ctrl_alu_done,
  output logic [DATA_W-1:0] o_ctrl_operand_a,
  output logic [DATA_W-1:0] o_ctrl_operand_b,
  output logic [3:0]        o_ctrl_opcode,
  output logic              o_ctrl_alu_start,
  output logic              o_ctrl_hex_new_input,
  output logic [DATA_W-1:0] o_ctrl_display,
  output logic              o_ctrl_error,
  output logic [2:0]        o_ctrl_state
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  state_e            r_state;
  logic [3:0]        r_opcode;
  logic              r_start;
  logic              r_new_input;
  logic              r_error;
  logic              r_neg_prev;
  logic              r_b_has;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;

  logic              w_clr, w_eq, w_op, w_dig, w_neg_edge;
  logic              w_res_op, w_res_dig;
  logic              w_a_load, w_a_dig, w_a_tog, w_a_acc;
  logic              w_b_clr, w_b_dig, w_b_tog, w_b_acc;
  logic [DATA_W-1:0] w_a_load_val, w_opa, w_opb;

  // Priority: clear > equals > operator > digit.
  always_comb begin
    w_clr        = i_ctrl_hex_valid && (i_ctrl_hex_keycode == KEY_CLR);
    w_eq         = i_ctrl_hex_valid && (i_ctrl_hex_keycode == KEY_EQ);
    w_op         = i_ctrl_op_valid && !w_clr && !w_eq;
    w_dig        = i_ctrl_hex_valid && (i_ctrl_hex_keycode <= 4'd9) && !i_ctrl_op_valid;
    w_neg_edge   = i_ctrl_neg_flag && !r_neg_prev;
    w_res_op     = (r_state == S_RES) && w_op;
    w_res_dig    = (r_state == S_RES) && w_dig;
    w_a_load     = w_res_op || w_res_dig;
    w_a_load_val = w_res_op ? r_result : {{(DATA_W-4){1'b0}}, i_ctrl_hex_keycode};
    w_a_dig      = (r_state == S_OPA) && w_dig;
    w_a_tog      = (r_state == S_OPA) && w_neg_edge && !w_clr;
    w_b_clr      = w_clr || w_a_load;
    w_b_dig      = (r_state == S_OPB) && w_dig;
    w_b_tog      = (r_state == S_OPB) && w_neg_edge && !w_clr;
  end

  calc_digit_acc #(.DATA_W(DATA_W), .MAX_MAG(MAX_MAG)) u_acc_a (
    .i_clk        (i_sys_clock),
    .i_rst        (i_sys_reset),
    .i_clear      (w_clr),
    .i_load       (w_a_load),
    .i_load_value (w_a_load_val),
    .i_digit_valid(w_a_dig),
    .i_digit      (i_ctrl_hex_keycode),
    .i_toggle     (w_a_tog),
    .o_accept     (w_a_acc),
    .o_operand    (w_opa)
  );

  calc_digit_acc #(.DATA_W(DATA_W), .MAX_MAG(MAX_MAG)) u_acc_b (
    .i_clk        (i_sys_clock),
    .i_rst        (i_sys_reset),
    .i_clear      (w_b_clr),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_digit_valid(w_b_dig),
    .i_digit      (i_ctrl_hex_keycode),
    .i_toggle     (w_b_tog),
    .o_accept     (w_b_acc),
    .o_operand    (w_opb)
  );

  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      r_state     <= S_OPA;
      r_opcode    <= OP_NONE;
      r_start     <= 1'b0;
      r_new_input <= 1'b0;
      r_error     <= 1'b0;
      r_neg_prev  <= 1'b0;
      r_b_has     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
    end else begin
      r_start     <= 1'b0;
      r_neg_prev  <= i_ctrl_neg_flag;
      r_new_input <= w_a_acc || w_b_acc || w_res_dig || w_clr;
      if (w_b_acc) r_b_has <= 1'b1;
      if (w_clr) begin
        r_state  <= S_OPA;
        r_opcode <= OP_NONE;
        r_error  <= 1'b0;
        r_b_has  <= 1'b0;
        r_cnt    <= '0;
        r_result <= '0;
      end else begin
        case (r_state)
          S_OPA: if (w_op) begin
            r_opcode <= i_ctrl_op_keycode;
            r_state  <= (i_ctrl_op_keycode == OP_NOT) ? S_RDY : S_OPB;
          end
          S_OPB: begin
            if (w_eq && r_b_has) r_state <= S_EXEC;
            else if (w_op && !r_b_has) begin
              r_opcode <= i_ctrl_op_keycode;
              if (i_ctrl_op_keycode == OP_NOT) r_state <= S_RDY;
            end
          end
          S_RDY: if (w_eq) r_state <= S_EXEC;
          S_EXEC: begin
            if ((r_opcode == OP_DIV) && (w_opb == '0)) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_start <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (i_ctrl_alu_done) begin
              r_result <= i_ctrl_alu_result;
              r_state  <= i_ctrl_alu_error ? S_ERR : S_RES;
              r_error  <= i_ctrl_alu_error;
            end else if (r_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RES: begin
            if (w_op) begin
              r_opcode <= i_ctrl_op_keycode;
              r_b_has  <= 1'b0;
              r_state  <= (i_ctrl_op_keycode == OP_NOT) ? S_RDY : S_OPB;
            end else if (w_dig) begin
              r_opcode <= OP_NONE;
              r_b_has  <= 1'b0;
              r_state  <= S_OPA;
            end
          end
          S_ERR:   r_state <= S_ERR;
          default: r_state <= S_OPA;
        endcase
      end
    end
  end

  always_comb begin
    case (r_state)
      S_OPA, S_RDY:   o_ctrl_display = w_opa;
      S_OPB:          o_ctrl_display = w_opb;
      S_EXEC, S_WAIT: o_ctrl_display = (r_opcode == OP_NOT) ? w_opa : w_opb;
      S_RES:          o_ctrl_display = r_result;
      default:        o_ctrl_display = '0;
    endcase
  end

  assign o_ctrl_operand_a     = w_opa;
  assign o_ctrl_operand_b     = w_opb;
  assign o_ctrl_opcode        = r_opcode;
  assign o_ctrl_alu_start     = r_start;
  assign o_ctrl_hex_new_input = r_new_input;
  assign o_ctrl_error         = r_error;
  assign o_ctrl_state         = r_state;

endmodule
`default_nettype wire

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Top-level entry sequencer for the 8-bit calculator. It takes decoded keys from the digit keypad block and from the operator keypad block (keycode, valid pulse, negative flag), and builds signed operands A and B. It then issues one start pulse to the ALU, waits for the ALU's done signal, and holds the result or error for the display. It also returns the hex-new-input pulse that clears the operator block's negative flag.

Parameters:
DATA_W, 8, operand/result width (two's complement)
MAX_MAG, 127, largest magnitude accepted during digit entry
ALU_TIMEOUT, 16, cycles to wait for i_ctrl_alu_done before declaring error

Ports:
i_sys_clock  in  1  system clock
i_sys_reset  in  1  synchronous active-high reset
i_ctrl_hex_keycode  in  4  digit keypad code: 0-9 digit, 4'hE equals, 4'hF clear, others ignored
i_ctrl_hex_valid  in  1  1-cycle pulse, hex keycode valid
i_ctrl_op_keycode  in  4  operator code 0-11 (add..arith-left-shift)
i_ctrl_op_valid  in  1  1-cycle pulse, operator keycode valid
i_ctrl_neg_flag  in  1  change-sign level from operator keypad block
i_ctrl_alu_result  in  DATA_W  ALU result
i_ctrl_alu_error  in  1  ALU overflow/illegal flag, sampled with done
i_ctrl_alu_done  in  1  1-cycle pulse, result valid
o_ctrl_operand_a  out  DATA_W  signed operand A to ALU
o_ctrl_operand_b  out  DATA_W  signed operand B to ALU
o_ctrl_opcode  out  4  latched operator to ALU
o_ctrl_alu_start  out  1  1-cycle start pulse
o_ctrl_hex_new_input  out  1  1-cycle pulse on every accepted digit
o_ctrl_display  out  DATA_W  value to show (current operand or result)
o_ctrl_error  out  1  error indication, held until clear
o_ctrl_state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (sync, i_sys_reset high at clock edge): state S_OPA. Operands, display and magnitudes 0. Opcode 4'hF. Sign bits 0. All pulses 0. o_ctrl_error 0. Timeout counter 0. Reset mid-ALU-wait abandons the operation, and a later done is ignored.
- Event priority in one cycle: clear > equals > operator > digit. Lower-priority events in the same cycle are discarded.
- Clear (hex 4'hF) in any state: return to reset values except o_ctrl_hex_new_input, which pulses once.
- Digit accept: next_mag = mag*10 + digit, computed in 11 bits.
  - If next_mag > MAX_MAG, the digit is ignored with no pulse.
  - Otherwise mag is updated and o_ctrl_hex_new_input pulses on the next cycle.
  - Operand = sign ? -mag : mag, truncated to DATA_W.
- Sign: a 0->1 edge on i_ctrl_neg_flag (registered previous value) toggles the sign of the operand currently being entered. Edges are ignored in S_EXEC, S_WAIT and S_ERR.
- States:
  - S_OPA: digits build A, and display = A. An operator latches the opcode and moves to S_OPB. For NOT (4'h4) it moves to S_RDY instead. Equals is ignored.
  - S_OPB: digits build B, and display = B. An operator with no B digit yet replaces the opcode. Equals with at least one B digit goes to S_EXEC. Equals with no B digit is ignored.
  - S_RDY (unary): equals goes to S_EXEC. Digits are ignored.
  - S_EXEC: if opcode is divide (4'h3) and B == 0, go to S_ERR with no start. Otherwise assert o_ctrl_alu_start for exactly 1 cycle, then go to S_WAIT.
  - S_WAIT: count cycles.
    - On done: display = result. If i_ctrl_alu_error, go to S_ERR; else go to S_RES.
    - When the count reaches ALU_TIMEOUT without done, go to S_ERR.
  - S_RES: holds the result.
    - An operator chains: A <= result, B cleared, opcode latched, then S_OPB (or S_RDY for NOT).
    - A digit starts a new calculation: A = that digit, then S_OPA.
  - S_ERR: o_ctrl_error = 1 and display = 0. Only clear exits.
- Operands and opcode stay stable from S_EXEC until done or timeout.
- Latency: equals pulse -> start pulse is 2 cycles (S_EXEC registered).

Decomposition:
- Package calc_pkg holds:
  - the state enum (S_OPA, S_OPB, S_RDY, S_EXEC, S_WAIT, S_RES, S_ERR);
  - opcode localparams (OP_ADD=0 .. OP_ASL=11, OP_NOT=4, OP_DIV=3, OP_NONE=4'hF);
  - hex key localparams KEY_EQ=4'hE and KEY_CLR=4'hF.
- One sub-module, calc_digit_acc: mag/sign accumulator with MAX_MAG check, toggle, clear, and a signed output. It is instantiated twice (A and B).

Test Plan:
- Press 1,2,3, op ADD, 4,5, equals; ALU done one cycle after start with result 168 and error 1 -> start pulses once, A=123, B=45, opcode 0, S_ERR, o_ctrl_error=1.
- Press 5, neg edge, op SUB, 3, equals; ALU returns 8'hF8 -> A=8'hFB, B=3, display 8'hF8, state S_RES.
- Press 9, op DIV, 0, equals -> no start pulse, S_ERR, error=1; then clear -> S_OPA, all outputs reset.
- Press 1,2,8 -> digit 8 rejected (128 > 127), A=12, only 2 hex_new_input pulses; then op NOT, equals -> start with opcode 4.
- Start issued and no done for 16 cycles -> S_ERR on cycle 16; a late done pulse is ignored.
- Same-cycle clear and op_valid in S_OPB -> clear wins, opcode 4'hF. Result chaining: S_RES with 20, then op MUL, 3, equals -> A=20, B=3, opcode 2.
